// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the 16-bit core: sequences fetch/decode/execute/mem/writeback,
// decodes datapath selects and strobes, counts retired instructions and detects memory timeouts.
module multicycle_ctrl_fsm #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             C_ALUSrc_A,
  output logic [2:0]       C_ALUSrc_B,
  output logic [1:0]       C_RegDstRead1R,
  output logic             C_RegDstRead2R,
  output logic             C_SignExtend,
  output logic [1:0]       alu_op,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             PCSource,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted,
  output logic             illegal,
  output logic             mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ORI  = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] B_REG2 = 3'b000;
  localparam logic [2:0] B_ONE  = 3'b001;
  localparam logic [2:0] B_IMM8 = 3'b010;
  localparam logic [2:0] B_SESH = 3'b011;
  localparam logic [2:0] B_SE12 = 3'b100;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       opc_q, opc_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic             mem_err_q, mem_err_d;

  logic pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, m2r;
  logic strobe_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      opc_q     <= 4'h0;
      wait_q    <= 8'd0;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    opc_d          = opc_q;
    wait_d         = wait_q;
    cnt_d          = cnt_q;
    halted_d       = halted_q;
    illegal_d      = illegal_q;
    mem_err_d      = mem_err_q;
    C_ALUSrc_A     = 1'b0;
    C_ALUSrc_B     = B_REG2;
    C_RegDstRead2R = 1'b0;
    C_SignExtend   = 1'b0;
    alu_op         = ALU_ADD;
    PCSource       = 1'b0;
    pc_wr          = 1'b0;
    ir_wr          = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    reg_wr         = 1'b0;
    m2r            = 1'b0;

    case (state_q)
      S_FETCH: begin
        C_ALUSrc_B = B_ONE;
        mem_rd     = 1'b1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          opc_d   = opcode;
          wait_d  = 8'd0;
          state_d = S_DECODE;
        end else if (wait_q == TIMEOUT) begin
          mem_rd    = 1'b0;
          mem_err_d = 1'b1;
          halted_d  = 1'b1;
          wait_d    = 8'd0;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        C_ALUSrc_B = B_SESH;
        case (opc_q)
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_JMP: state_d = S_EXEC;
          default: begin
            illegal_d = 1'b1;
            cnt_d     = cnt_q + CNT_ONE;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_EXEC: begin
        C_ALUSrc_A = 1'b1;
        case (opc_q)
          OP_R: begin
            C_ALUSrc_B = B_REG2;
            alu_op     = ALU_FUNCT;
            state_d    = S_WB;
          end
          OP_ADDI: begin
            C_ALUSrc_B   = B_IMM8;
            C_SignExtend = 1'b1;
            state_d      = S_WB;
          end
          OP_ORI: begin
            C_ALUSrc_B = B_IMM8;
            alu_op     = ALU_OR;
            state_d    = S_WB;
          end
          OP_LW, OP_SW: begin
            C_ALUSrc_B     = B_IMM8;
            C_SignExtend   = 1'b1;
            C_RegDstRead2R = (opc_q == OP_SW);
            state_d        = S_MEM;
          end
          OP_BEQ: begin
            C_ALUSrc_B = B_REG2;
            alu_op     = ALU_SUB;
            pc_wr      = alu_zero;
            PCSource   = 1'b1;
            cnt_d      = cnt_q + CNT_ONE;
            state_d    = S_FETCH;
          end
          OP_JMP: begin
            C_ALUSrc_A = 1'b0;
            C_ALUSrc_B = B_SE12;
            pc_wr      = 1'b1;
            cnt_d      = cnt_q + CNT_ONE;
            state_d    = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_rd = (opc_q == OP_LW);
        mem_wr = (opc_q == OP_SW);
        if (mem_ready) begin
          wait_d = 8'd0;
          if (opc_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = S_FETCH;
          end
        end else if (wait_q == TIMEOUT) begin
          mem_rd    = 1'b0;
          mem_wr    = 1'b0;
          mem_err_d = 1'b1;
          halted_d  = 1'b1;
          wait_d    = 8'd0;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      S_WB: begin
        reg_wr  = 1'b1;
        m2r     = (opc_q == OP_LW);
        cnt_d   = cnt_q + CNT_ONE;
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are suppressed while frozen or held in reset so no partial write can leak out.
  assign strobe_en = en & rst_n;

  assign PCWrite        = pc_wr  & strobe_en;
  assign IRWrite        = ir_wr  & strobe_en;
  assign MemRead        = mem_rd & strobe_en;
  assign MemWrite       = mem_wr & strobe_en;
  assign RegWrite       = reg_wr & strobe_en;
  assign MemtoReg       = m2r    & strobe_en;
  assign C_RegDstRead1R = 2'b00;
  assign instr_count    = cnt_q;
  assign halted         = halted_q;
  assign illegal        = illegal_q;
  assign mem_err        = mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: expectations are queued per cycle and
// compared against the DUT on the falling clock edge.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  opcode;
  logic        alu_zero;
  logic        mem_ready;
  logic        C_ALUSrc_A;
  logic [2:0]  C_ALUSrc_B;
  logic [1:0]  C_RegDstRead1R;
  logic        C_RegDstRead2R;
  logic        C_SignExtend;
  logic [1:0]  alu_op;
  logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, PCSource;
  logic [15:0] instr_count;
  logic        halted, illegal, mem_err;

  multicycle_ctrl_fsm #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .C_ALUSrc_A(C_ALUSrc_A), .C_ALUSrc_B(C_ALUSrc_B),
    .C_RegDstRead1R(C_RegDstRead1R), .C_RegDstRead2R(C_RegDstRead2R),
    .C_SignExtend(C_SignExtend), .alu_op(alu_op), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .PCSource(PCSource), .instr_count(instr_count), .halted(halted), .illegal(illegal),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;
    logic [16:0] exp;
  } sbEntry_t;

  sbEntry_t    sbQueue[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] expCount;
  logic [2:0]  expFlags;
  logic [16:0] ctrlObs;

  logic [16:0] cFetchGo, cFetchWait, cFetchIdle, cDecode, cExecR, cExecAddi, cExecOri;
  logic [16:0] cExecLw, cExecSw, cExecBeq1, cExecBeq0, cExecJmp, cMemLw, cMemSw;
  logic [16:0] cWbLw, cWbAlu, cIdle;

  assign ctrlObs = {C_ALUSrc_A, C_ALUSrc_B, C_RegDstRead1R, C_RegDstRead2R, C_SignExtend,
                    alu_op, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, PCSource};

  // Strobe field order: PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemtoReg, PCSource.
  function automatic logic [16:0] ctl(input logic a, input logic [2:0] b, input logic r2,
                                      input logic se, input logic [1:0] op,
                                      input logic [6:0] strobes);
    return {a, b, 2'b00, r2, se, op, strobes};
  endfunction

  task automatic pushExp(input string tag, input int kind, input logic [16:0] exp);
    sbEntry_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic e, input logic [3:0] op, input logic z, input logic r);
    en        = e;
    opcode    = op;
    alu_zero  = z;
    mem_ready = r;
  endtask

  task automatic checkOutput();
    sbEntry_t    e;
    logic [16:0] obs;
    @(negedge clk);
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      case (e.kind)
        0:       obs = ctrlObs;
        1:       obs = {1'b0, instr_count};
        default: obs = {14'b0, halted, illegal, mem_err};
      endcase
      vectors++;
      assert (obs === e.exp)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic pushAll(input string tag, input logic [16:0] expCtrl);
    pushExp({tag, ".ctrl"}, 0, expCtrl);
    pushExp({tag, ".count"}, 1, {1'b0, expCount});
    pushExp({tag, ".flags"}, 2, {14'b0, expFlags});
  endtask

  task automatic step(input string tag, input logic e, input logic [3:0] op, input logic z,
                      input logic r, input logic [16:0] expCtrl);
    applyStimulus(e, op, z, r);
    pushAll(tag, expCtrl);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across one rising edge; everything must read back as reset values meanwhile.
  task automatic resetPulse(input string tag);
    rst_n    = 1'b0;
    expCount = 16'd0;
    expFlags = 3'b000;
    pushAll(tag, cFetchIdle);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic runWb(input string tag, input logic [3:0] op, input logic [16:0] execCtrl);
    step({tag, ".F"}, 1'b1, op, 1'b0, 1'b1, cFetchGo);
    step({tag, ".D"}, 1'b1, op, 1'b0, 1'b1, cDecode);
    step({tag, ".E"}, 1'b1, op, 1'b0, 1'b1, execCtrl);
    step({tag, ".W"}, 1'b1, op, 1'b0, 1'b1, cWbAlu);
    expCount = expCount + 16'd1;
  endtask

  initial begin
    cFetchGo   = ctl(1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 7'b1110000);
    cFetchWait = ctl(1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 7'b0010000);
    cFetchIdle = ctl(1'b0, 3'b001, 1'b0, 1'b0, 2'b00, 7'b0000000);
    cDecode    = ctl(1'b0, 3'b011, 1'b0, 1'b0, 2'b00, 7'b0000000);
    cExecR     = ctl(1'b1, 3'b000, 1'b0, 1'b0, 2'b10, 7'b0000000);
    cExecAddi  = ctl(1'b1, 3'b010, 1'b0, 1'b1, 2'b00, 7'b0000000);
    cExecOri   = ctl(1'b1, 3'b010, 1'b0, 1'b0, 2'b11, 7'b0000000);
    cExecLw    = ctl(1'b1, 3'b010, 1'b0, 1'b1, 2'b00, 7'b0000000);
    cExecSw    = ctl(1'b1, 3'b010, 1'b1, 1'b1, 2'b00, 7'b0000000);
    cExecBeq1  = ctl(1'b1, 3'b000, 1'b0, 1'b0, 2'b01, 7'b1000001);
    cExecBeq0  = ctl(1'b1, 3'b000, 1'b0, 1'b0, 2'b01, 7'b0000001);
    cExecJmp   = ctl(1'b0, 3'b100, 1'b0, 1'b0, 2'b00, 7'b1000000);
    cMemLw     = ctl(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 7'b0010000);
    cMemSw     = ctl(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 7'b0001000);
    cWbLw      = ctl(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 7'b0000110);
    cWbAlu     = ctl(1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 7'b0000100);
    cIdle      = 17'd0;

    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    resetPulse("reset");

    runWb("addi", 4'h1, cExecAddi);

    step("lw.F", 1'b1, 4'h3, 1'b0, 1'b1, cFetchGo);
    step("lw.D", 1'b1, 4'h3, 1'b0, 1'b1, cDecode);
    step("lw.E", 1'b1, 4'h3, 1'b0, 1'b1, cExecLw);
    for (int i = 0; i < 3; i++) step("lw.Mwait", 1'b1, 4'h3, 1'b0, 1'b0, cMemLw);
    step("lw.Mdone", 1'b1, 4'h3, 1'b0, 1'b1, cMemLw);
    step("lw.W", 1'b1, 4'h3, 1'b0, 1'b1, cWbLw);
    expCount = expCount + 16'd1;

    step("sw.F", 1'b1, 4'h4, 1'b0, 1'b1, cFetchGo);
    step("sw.D", 1'b1, 4'h4, 1'b0, 1'b1, cDecode);
    step("sw.E", 1'b1, 4'h4, 1'b0, 1'b1, cExecSw);
    step("sw.M", 1'b1, 4'h4, 1'b0, 1'b1, cMemSw);
    expCount = expCount + 16'd1;

    step("beq1.F", 1'b1, 4'h5, 1'b0, 1'b1, cFetchGo);
    step("beq1.D", 1'b1, 4'h5, 1'b0, 1'b1, cDecode);
    step("beq1.E", 1'b1, 4'h5, 1'b1, 1'b1, cExecBeq1);
    expCount = expCount + 16'd1;
    step("beq0.F", 1'b1, 4'h5, 1'b0, 1'b1, cFetchGo);
    step("beq0.D", 1'b1, 4'h5, 1'b0, 1'b1, cDecode);
    step("beq0.E", 1'b1, 4'h5, 1'b0, 1'b1, cExecBeq0);
    expCount = expCount + 16'd1;

    runWb("rtype", 4'h0, cExecR);
    runWb("ori", 4'h2, cExecOri);

    step("jmp.F", 1'b1, 4'h6, 1'b0, 1'b1, cFetchGo);
    step("jmp.D", 1'b1, 4'h6, 1'b0, 1'b1, cDecode);
    step("jmp.E", 1'b1, 4'h6, 1'b0, 1'b1, cExecJmp);
    expCount = expCount + 16'd1;

    step("ill.F", 1'b1, 4'h9, 1'b0, 1'b1, cFetchGo);
    step("ill.D", 1'b1, 4'h9, 1'b0, 1'b1, cDecode);
    expCount = expCount + 16'd1;
    expFlags = 3'b010;

    // mem_ready stays high while frozen: any movement would show up as the wrong phase.
    step("frz.Fhold", 1'b0, 4'h3, 1'b0, 1'b1, cFetchIdle);
    step("frz.F", 1'b1, 4'h3, 1'b0, 1'b1, cFetchGo);
    step("frz.D", 1'b1, 4'h3, 1'b0, 1'b1, cDecode);
    step("frz.E", 1'b1, 4'h3, 1'b0, 1'b1, cExecLw);
    step("frz.Mhold", 1'b0, 4'h3, 1'b0, 1'b1, cIdle);
    step("frz.Mhold", 1'b0, 4'h3, 1'b0, 1'b1, cIdle);
    step("frz.M", 1'b1, 4'h3, 1'b0, 1'b1, cMemLw);
    step("frz.W", 1'b1, 4'h3, 1'b0, 1'b1, cWbLw);
    expCount = expCount + 16'd1;

    step("swrst.F", 1'b1, 4'h4, 1'b0, 1'b1, cFetchGo);
    step("swrst.D", 1'b1, 4'h4, 1'b0, 1'b1, cDecode);
    step("swrst.E", 1'b1, 4'h4, 1'b0, 1'b1, cExecSw);
    step("swrst.M", 1'b1, 4'h4, 1'b0, 1'b0, cMemSw);
    resetPulse("swrst.rst");

    step("halt.F", 1'b1, 4'hF, 1'b0, 1'b1, cFetchGo);
    step("halt.D", 1'b1, 4'hF, 1'b0, 1'b1, cDecode);
    expFlags = 3'b100;
    for (int i = 0; i < 3; i++) step("halt.H", 1'b1, 4'h1, 1'b0, 1'b1, cIdle);
    resetPulse("halt.rst");

    for (int i = 0; i < 15; i++) step("tmo.wait", 1'b1, 4'h1, 1'b0, 1'b0, cFetchWait);
    step("tmo.hit", 1'b1, 4'h1, 1'b0, 1'b0, cFetchIdle);
    expFlags = 3'b101;
    for (int i = 0; i < 2; i++) step("tmo.H", 1'b1, 4'h1, 1'b0, 1'b1, cIdle);
    resetPulse("tmo.rst");

    for (int i = 0; i < 15; i++) step("tie.wait", 1'b1, 4'h1, 1'b0, 1'b0, cFetchWait);
    runWb("tie", 4'h1, cExecAddi);
    step("tie.after", 1'b1, 4'h1, 1'b0, 1'b0, cFetchWait);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
